// File: rtl/inst_fetch_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : inst_fetch_if                                               |
// | Purpose  : Bundles the signals of the instruction fetch stage: the     |
// |            instruction-memory req/gnt/rvalid handshake, the redirect   |
// |            request from ID/EX and the valid/stall handshake to ID.     |
// | Modports : master - fetch stage (drives imem_req/imem_addr and the     |
// |                     inst_* outputs)                                    |
// |            slave  - environment (memory, ID/EX)                        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface inst_fetch_if #(
  parameter int W = 32
);
  // instruction memory
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [W-1:0] imem_rdata;
  // control flow change from ID/EX
  logic         redirect;
  logic [W-1:0] redirect_pc;
  // decoder side
  logic         stall;
  logic         inst_valid;
  logic [W-1:0] inst;
  logic [W-1:0] inst_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc, stall,
    output inst_valid, inst, inst_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc, stall,
    input  inst_valid, inst, inst_pc
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : inst_fetch                                                  |
// | Purpose  : Instruction fetch stage. Holds the PC, issues word fetches  |
// |            over a req/gnt/rvalid handshake, buffers returned words     |
// |            with their PCs in an in-order queue and hands them to ID    |
// |            with a valid/stall handshake. Redirects flush the queue and |
// |            discard responses still in flight.                          |
// | Ports    : clk   - clock                                               |
// |            rst   - synchronous active-high reset                       |
// |            bus   - inst_fetch_if.master (imem_*, redirect*, stall,     |
// |                    inst_valid, inst, inst_pc)                          |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module inst_fetch #(
  parameter int           W          = 32,
  parameter logic [W-1:0] RESET_PC   = 32'hBFC0_0000,
  parameter int           FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  // FIFO_DEPTH is a power of two >= 2, so pointers wrap naturally.
  localparam int AW = $clog2(FIFO_DEPTH);
  // Occupancy counters must be able to hold FIFO_DEPTH itself.
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  // Back-to-back redirects can stack up to 2*FIFO_DEPTH stale responses.
  localparam int KW = $clog2(2 * FIFO_DEPTH + 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [W-1:0]  pc;

  // returned-word queue {pc, word}
  logic [W-1:0]  q_pc   [FIFO_DEPTH];
  logic [W-1:0]  q_word [FIFO_DEPTH];
  logic [AW-1:0] q_rd;
  logic [AW-1:0] q_wr;
  logic [CW-1:0] fcnt;

  // addresses of granted fetches whose data has not returned yet
  logic [W-1:0]  aq     [FIFO_DEPTH];
  logic [AW-1:0] aq_rd;
  logic [AW-1:0] aq_wr;
  logic [CW-1:0] ocnt;

  // responses still owed by memory for fetches abandoned by a redirect
  logic [KW-1:0] kcnt;

  // ---------------------------------------------------------------------
  // Combinational handshake logic
  // ---------------------------------------------------------------------
  logic          valid;
  logic          deq;
  logic          credit;
  logic          req;
  logic          grant;
  logic          kill;
  logic          accept;
  logic [CW:0]   used;

  assign valid  = (fcnt != '0);
  assign deq    = valid & ~bus.stall;

  // Slots already claimed after this cycle's pop; a new fetch is only
  // issued when its word is guaranteed a queue entry on return.
  assign used   = {1'b0, fcnt} + {1'b0, ocnt} - {{CW{1'b0}}, deq};
  assign credit = (used < (CW+1)'(FIFO_DEPTH));

  // Redirect withdraws the request so the stale PC is never granted;
  // the new PC goes out on the following cycle.
  assign req    = ~rst & ~bus.redirect & credit;
  assign grant  = req & bus.imem_gnt;

  // Stale responses drain first; an rvalid with nothing owed is ignored.
  assign kill   = bus.imem_rvalid & (kcnt != '0);
  assign accept = bus.imem_rvalid & (kcnt == '0) & (ocnt != '0);

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = valid;
  assign bus.inst       = valid ? q_word[q_rd] : '0;
  assign bus.inst_pc    = valid ? q_pc[q_rd]   : '0;

  // ---------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      q_rd  <= '0;
      q_wr  <= '0;
      fcnt  <= '0;
      aq_rd <= '0;
      aq_wr <= '0;
      ocnt  <= '0;
      kcnt  <= '0;
    end else if (bus.redirect) begin
      // Everything outstanding becomes stale. A response arriving right
      // now (killed or not) is discarded, so it is already paid for.
      pc    <= {bus.redirect_pc[W-1:2], 2'b00};
      q_rd  <= '0;
      q_wr  <= '0;
      fcnt  <= '0;
      aq_rd <= '0;
      aq_wr <= '0;
      ocnt  <= '0;
      kcnt  <= kcnt + KW'(ocnt) - KW'(kill | accept);
    end else begin
      if (grant) begin
        pc    <= pc + W'(4);
        aq_wr <= aq_wr + AW'(1);
      end
      if (accept) begin
        q_wr  <= q_wr + AW'(1);
        aq_rd <= aq_rd + AW'(1);
      end
      if (deq) begin
        q_rd  <= q_rd + AW'(1);
      end
      if (kill) begin
        kcnt  <= kcnt - KW'(1);
      end
      fcnt <= fcnt + CW'(accept) - CW'(deq);
      ocnt <= ocnt + CW'(grant) - CW'(accept);
    end
  end

  // ---------------------------------------------------------------------
  // Queue storage (no reset needed: entries are qualified by the counts)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && !bus.redirect) begin
      if (grant) begin
        aq[aq_wr] <= pc;
      end
      if (accept) begin
        q_pc[q_wr]   <= aq[aq_rd];
        q_word[q_wr] <= bus.imem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_inst_fetch                                               |
// | Purpose  : Self-checking bench for inst_fetch. A memory model answers  |
// |            grants in order with a configurable latency; a queue-based  |
// |            reference model of the fetch stage predicts every output    |
// |            each cycle. Directed scenarios are followed by randomized   |
// |            traffic.                                                    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_inst_fetch;

  localparam int          W        = 32;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if #(.W(W)) bus ();

  inst_fetch #(
    .W          (W),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // memory model
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t pend[$];
  int    last_due = 0;
  int    lat_min  = 1;
  int    lat_max  = 1;

  // reference model of the fetch stage
  typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;
  ent_t        m_buf[$];
  logic [31:0] m_out[$];
  int          m_kill = 0;
  logic [31:0] m_pc   = RESET_PC;

  // DUT observations from the latest step
  bit          last_req;
  logic [31:0] last_addr;
  bit          last_valid;
  logic [31:0] last_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, compare outputs against the
  // model, then advance model and memory at the posedge.
  task automatic step(input bit r, input bit redir, input logic [31:0] rpc,
                      input bit st, input bit g, input bit stray);
    bit          rv;
    bit          rv_mem;
    logic [31:0] rd;
    bit          e_valid;
    bit          e_deq;
    bit          e_req;
    bit          dropped;
    int          occ;
    int          due;
    bit          d_req;
    logic [31:0] d_addr;
    ent_t        e;

    @(negedge clk);
    rv     = 1'b0;
    rv_mem = 1'b0;
    rd     = $urandom;
    if (!r) begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rv     = 1'b1;
        rv_mem = 1'b1;
        rd     = mem_word(pend[0].addr);
      end else if (stray && pend.size() == 0) begin
        rv = 1'b1;
      end
    end
    rst             = r;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.stall       = st;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    #1;

    e_valid = (m_buf.size() != 0);
    e_deq   = e_valid && !st;
    occ     = m_buf.size() + m_out.size() - (e_deq ? 1 : 0);
    e_req   = !r && !redir && (occ < DEPTH);

    if (chk_en) begin
      check("inst_valid", {31'b0, bus.inst_valid}, {31'b0, e_valid});
      check("inst",       bus.inst,    e_valid ? m_buf[0].word : 32'h0);
      check("inst_pc",    bus.inst_pc, e_valid ? m_buf[0].pc   : 32'h0);
      check("imem_req",   {31'b0, bus.imem_req}, {31'b0, e_req});
      if (e_req) check("imem_addr", bus.imem_addr, m_pc);
    end
    d_req      = bus.imem_req;
    d_addr     = bus.imem_addr;
    last_req   = d_req;
    last_addr  = d_addr;
    last_valid = bus.inst_valid;
    last_ipc   = bus.inst_pc;

    @(posedge clk);

    // reference model
    if (r) begin
      m_pc   = RESET_PC;
      m_kill = 0;
      m_buf.delete();
      m_out.delete();
    end else if (redir) begin
      dropped = rv && (m_kill > 0 || m_out.size() > 0);
      m_kill  = m_kill + m_out.size() - (dropped ? 1 : 0);
      m_out.delete();
      m_buf.delete();
      m_pc    = {rpc[31:2], 2'b00};
    end else begin
      if (e_deq) void'(m_buf.pop_front());
      if (rv) begin
        if (m_kill > 0) begin
          m_kill--;
        end else if (m_out.size() > 0) begin
          e.pc   = m_out.pop_front();
          e.word = mem_word(e.pc);
          m_buf.push_back(e);
        end
      end
      if (e_req && g) begin
        m_out.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end

    // memory model: reacts to what the DUT actually issued
    if (r) begin
      pend.delete();
    end else begin
      if (rv_mem) void'(pend.pop_front());
      if (d_req && g) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{addr: d_addr, due: due});
      end
    end
    cyc++;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic [31:0] rpc;
    int          gpct;
    int          spct;
    int          rpct;

    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.stall       = 1'b0;

    // reset: first cycle has unknown state, so checks start on the second
    step(1, 0, 32'h0, 0, 1, 0);
    chk_en = 1'b1;
    step(1, 0, 32'h0, 0, 1, 0);
    check("rst_valid", {31'b0, last_valid}, 32'h0);
    check("rst_req",   {31'b0, last_req},   32'h0);

    // latency 1, gnt always: first fetches, then stall while holding head
    lat_min = 1; lat_max = 1;
    step(0, 0, 32'h0, 0, 1, 0);
    check("first_addr", last_addr, 32'hBFC0_0000);
    step(0, 0, 32'h0, 0, 1, 0);
    check("second_addr", last_addr, 32'hBFC0_0004);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 32'h0, 1, 1, 0);
      check("stall_hold_pc", last_ipc, 32'hBFC0_0000);
    end
    check("stall_req_off", {31'b0, last_req}, 32'h0);
    for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 0, 1, 0);

    // flush, then two fetches in flight at latency 3 and a redirect
    step(0, 1, 32'h0000_1000, 0, 1, 0);
    lat_min = 3; lat_max = 3;
    step(0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 32'h0, 0, 1, 0);
    step(0, 1, 32'h8000_0102, 0, 1, 0);
    step(0, 0, 32'h0, 0, 1, 0);
    check("redir_addr", last_addr, 32'h8000_0100);
    check("redir_req",  {31'b0, last_req}, 32'h1);
    for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 0, 1, 0);

    // redirect coinciding with rvalid and a pop
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0, 1, 0);
    step(0, 1, 32'h0000_2000, 0, 1, 0);
    step(0, 0, 32'h0, 0, 1, 0);
    check("redir_flush", {31'b0, last_valid}, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 0, 1, 0);

    // no grant for 4 cycles: address must hold
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 1, 0);

    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFE, 0, 1, 0);
    step(0, 0, 32'h0, 0, 1, 0);
    check("wrap_top", last_addr, 32'hFFFF_FFFC);
    step(0, 0, 32'h0, 0, 1, 0);
    check("wrap_zero", last_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 1, 0);

    // reset with two fetches outstanding, then a stray rvalid
    lat_min = 3; lat_max = 3;
    step(0, 1, 32'h0000_3000, 0, 1, 0);
    step(0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 32'h0, 0, 1, 0);
    step(1, 0, 32'h0, 0, 1, 0);
    step(0, 0, 32'h0, 0, 0, 1);
    check("rst_mid_valid", {31'b0, last_valid}, 32'h0);
    check("rst_mid_addr",  last_addr, 32'hBFC0_0000);
    step(0, 0, 32'h0, 0, 1, 0);
    check("stray_ignored", {31'b0, last_valid}, 32'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 0, 1, 0);

    // randomized traffic
    for (int seg = 0; seg < 15; seg++) begin
      lat_min = 1;
      lat_max = $urandom_range(3, 1);
      gpct    = $urandom_range(100, 30);
      spct    = $urandom_range(60, 0);
      rpct    = $urandom_range(10, 0);
      for (int i = 0; i < 200; i++) begin
        rpc = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                          : 32'($urandom);
        step($urandom_range(299, 0) == 0,
             $urandom_range(99, 0) < rpct,
             rpc,
             $urandom_range(99, 0) < spct,
             $urandom_range(99, 0) < gpct,
             $urandom_range(49, 0) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage; the producer end of the instruction word consumed by the ID-stage decoder.
- Holds the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their PCs in a small in-order queue and presents them to ID with a valid/stall handshake.
- Handles branch/jump redirects by flushing buffered words and discarding in-flight responses.

Parameters:
- W, 32, word width (`WORD_WIDTH).
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction queue entries; also max outstanding fetches (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  W  fetch address; bits [1:0] always 2'b00.
- imem_gnt  in  1  request accepted this cycle; meaningful only when imem_req=1.
- imem_rvalid  in  1  response data valid; exactly one per grant, in order, latency >=1 cycle after gnt.
- imem_rdata  in  W  fetched instruction word.
- redirect  in  1  flush and restart at redirect_pc (branch/jump taken, from ID/EX).
- redirect_pc  in  W  new PC; bits [1:0] ignored.
- stall  in  1  ID cannot accept this cycle.
- inst_valid  out  1  inst/inst_pc hold a valid fetched word.
- inst  out  W  instruction word to decoder; `ZERO_WORD (NOP) when not valid.
- inst_pc  out  W  address of inst; `ZERO_WORD when not valid.

Behaviour:
- State: pc reg; queue of {pc, word} (FIFO_DEPTH entries, count fcnt); address queue for outstanding fetches (ocnt); kill counter kcnt.
- Reset (rst=1 at edge):
  - pc <= RESET_PC; fcnt, ocnt, kcnt <= 0.
  - Outputs next cycle: inst_valid=0, inst=0, inst_pc=0, imem_req=0 while rst=1.
  - Reset mid-operation abandons all in-flight fetches; memory is reset together with this block.
  - A stray rvalid seen while ocnt=0 and kcnt=0 is ignored.
- Consumption: deq = inst_valid & ~stall; the head pops at the edge.
- inst_valid = (fcnt != 0); inst/inst_pc are the queue head, combinational from registered state.
- Credit: imem_req = ~rst & ~redirect & (fcnt + ocnt - deq < FIFO_DEPTH). This is combinational; imem_addr = pc.
- Grant (imem_req & imem_gnt):
  - pc <= pc + 4, wrapping modulo 2^W (32'hFFFF_FFFC -> 0).
  - pc is pushed onto the address queue; ocnt++.
- Request stability: while imem_req=1 and ungranted, imem_addr is stable. The only exception is that redirect withdraws the request.
- Response (imem_rvalid):
  - If kcnt>0: kcnt--, word dropped.
  - Else if ocnt>0: {addr_queue head, imem_rdata} pushes into the queue; ocnt--.
  - The word becomes visible the cycle after rvalid, i.e. latency gnt(t) -> rvalid(t+1) -> inst_valid(t+2).
- Simultaneous push and pop in the same cycle: fcnt unchanged, order preserved. The queue never overflows, by credit.
- Redirect (redirect=1 at edge), highest priority after rst:
  - Queue flushed (fcnt <= 0).
  - kcnt <= kcnt + ocnt, minus 1 if a non-killed rvalid arrives that same cycle; that response is dropped. Then ocnt <= 0.
  - pc <= {redirect_pc[W-1:2], 2'b00}.
  - imem_req=0 in the redirect cycle; the new PC is requested on the next cycle.
  - A pop in the same cycle is void.
- Back-to-back redirects: each one adds outstanding fetches to kcnt; kcnt width covers 2*FIFO_DEPTH.
- Steady state: 1 fetch/cycle with FIFO_DEPTH=2, latency 1, stall=0.
- Stall held: fetching stops once fcnt + ocnt = FIFO_DEPTH; inst/inst_pc are held stable.

Test Plan:
- Reset then gnt always 1, latency 1, stall=0 -> imem_addr 0xBFC00000, 0xBFC00004, ... each cycle; inst_valid first high 2 cycles after the first grant; inst_pc sequence matches.
- stall=1 for 5 cycles after the first valid -> imem_req drops after 2 total outstanding+buffered; inst/inst_pc held at 0xBFC00000; after release, words are delivered in order with none lost or duplicated.
- Latency 3, two fetches outstanding, redirect to 0x80000102 -> both stale rvalids dropped (no inst_valid); next imem_addr = 0x80000100; first delivered inst_pc = 0x80000100.
- redirect coincident with rvalid and a pending pop -> that word is not delivered; queue is empty next cycle; no stale word appears later.
- imem_gnt=0 for 4 cycles with req high -> imem_addr stable; no pc advance.
- pc = 0xFFFFFFFC granted -> next imem_addr = 0x00000000.
- rst asserted with 2 outstanding -> inst_valid=0 next cycle; fetch restarts at 0xBFC00000.
